// File: rtl/mm_engine_scheduler.sv
// mm_engine_scheduler
//   Shares a single matrix-multiplication engine between NUM_REQ requesters. Arbitrates among
//   level requests, steers the engine input/result mux and sequences the engine enable/done
//   handshake. A watchdog aborts a job whose result never arrives.
//
//   Job flow: IDLE -> GRANT (mux settle) -> ARM (enable up, stale done ignored) -> RUN
//   (wait for done or timeout) -> HOLD (owner reads results) -> IDLE once the owner drops its
//   request. If the owner drops its request before HOLD, the job is abandoned silently.
//
// Configuration macro:
//   MM_SCHED_PRIORITY_EN  defined   : fixed priority, lowest index wins (host-first use)
//                         undefined : round-robin, search starts after the last owner
//
// Ports:
//   wb_clk_i      in   1        clock, rising edge
//   wb_rst_n_i    in   1        asynchronous active-low reset
//   req_i         in   NUM_REQ  level requests, held from job start until results are read
//   gnt_o         out  NUM_REQ  registered one-hot grant
//   eng_sel_o     out  SEL_W    index of the owner; holds its value while idle
//   eng_enable_o  out  1        engine enable
//   eng_done_i    in   1        engine result valid
//   done_o        out  NUM_REQ  one-cycle pulse to the owner: result valid
//   err_o         out  NUM_REQ  one-cycle pulse to the owner: watchdog abort
//   busy_o        out  1        a job is in progress (state is not IDLE)

module mm_engine_scheduler #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SEL_W          = 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0]   eng_sel_o,
  output logic               eng_enable_o,
  input  logic               eng_done_i,
  output logic [NUM_REQ-1:0] done_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic               busy_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMax = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StArm,
    StRun,
    StHold
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [SEL_W-1:0] win;
  logic            owner_drop;

  // The owner withdrawing its request ends the job in any non-idle state.
  assign owner_drop = ~req_i[eng_sel_o];

`ifdef MM_SCHED_PRIORITY_EN
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    win = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j]) win = SEL_W'(j);
    end
  end
`else
  logic [SEL_W-1:0]     ptr_q;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   rr_off;
  int                   rr_sum;

  // Round-robin: rotate the requests so bit 0 is the requester just after the last owner,
  // take the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = NUM_REQ'(req_dbl >> (int'(ptr_q) + 1));
    rr_off  = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) rr_off = j;
    end
    rr_sum = int'(ptr_q) + 1 + rr_off;
    if (rr_sum >= int'(NUM_REQ)) rr_sum = rr_sum - int'(NUM_REQ);
    win = SEL_W'(rr_sum);
  end
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      gnt_o        <= '0;
      eng_sel_o    <= '0;
      eng_enable_o <= 1'b0;
      done_o       <= '0;
      err_o        <= '0;
      busy_o       <= 1'b0;
`ifndef MM_SCHED_PRIORITY_EN
      // Points at the last requester so requester 0 wins the first arbitration.
      ptr_q        <= SEL_W'(NUM_REQ - 1);
`endif
    end else begin
      done_o <= '0;
      err_o  <= '0;
      if (state_q != StIdle && owner_drop) begin
        // Release: covers both the normal HOLD exit and a silent abort.
        state_q      <= StIdle;
        gnt_o        <= '0;
        eng_enable_o <= 1'b0;
        busy_o       <= 1'b0;
`ifndef MM_SCHED_PRIORITY_EN
        ptr_q        <= eng_sel_o;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (|req_i) begin
              state_q   <= StGrant;
              gnt_o     <= NUM_REQ'(1) << win;
              eng_sel_o <= win;
              busy_o    <= 1'b1;
            end
          end
          StGrant: begin
            state_q      <= StArm;
            eng_enable_o <= 1'b1;
          end
          StArm: begin
            // A done still asserted from the previous job is deliberately not looked at here.
            state_q <= StRun;
            timer_q <= '0;
          end
          StRun: begin
            if (eng_done_i) begin
              // Done beats a simultaneous timeout; enable stays up so results remain valid.
              state_q <= StHold;
              done_o  <= gnt_o;
            end else if (timer_q == TMax) begin
              state_q      <= StHold;
              err_o        <= gnt_o;
              eng_enable_o <= 1'b0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StHold: begin
            // Wait for the owner to drop its request (handled above).
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
